// File: rtl/rx_point_test_responder_pkg.sv
// Shared types for the RX point-test responder: message codes, FSM states,
// comparator control words and test-mode encodings.
package rx_pt_pkg;

  localparam int unsigned MSG_START_REQ  = 1;
  localparam int unsigned MSG_START_RESP = 2;
  localparam int unsigned MSG_CLR_REQ    = 3;
  localparam int unsigned MSG_CLR_RESP   = 4;
  localparam int unsigned MSG_RES_REQ    = 5;
  localparam int unsigned MSG_RES_RESP   = 6;
  localparam int unsigned MSG_END_REQ    = 7;
  localparam int unsigned MSG_END_RESP   = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_SEND_START,
    ST_WAIT_CLR,
    ST_SEND_CLR,
    ST_COMPARE,
    ST_WAIT_RES,
    ST_SEND_RES,
    ST_WAIT_END,
    ST_SEND_END,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    CW_OFF     = 2'b00,
    CW_CLR     = 2'b01,
    CW_LFSR    = 2'b10,
    CW_PERLANE = 2'b11
  } cmp_cw_e;

  localparam logic [1:0] MODE_LFSR    = 2'b00;
  localparam logic [1:0] MODE_PERLANE = 2'b01;
  localparam int unsigned MODE_VALID_BIT = 1;  // i_mode=1x selects valid-train

  // States in which the partner owes us something and the watchdog runs.
  function automatic logic is_timed(state_e s);
    return s inside {ST_WAIT_START, ST_WAIT_CLR, ST_COMPARE, ST_WAIT_RES, ST_WAIT_END};
  endfunction

  function automatic cmp_cw_e mode_to_cw(logic [1:0] mode);
    cmp_cw_e cw;
    cw = CW_OFF;
    if (mode == MODE_LFSR)         cw = CW_LFSR;
    else if (mode == MODE_PERLANE) cw = CW_PERLANE;
    return cw;
  endfunction

endpackage

// File: rtl/rx_point_test_responder_if.sv
// Sideband request/response bundle between the sideband link (master) and the
// point-test responder (slave).
interface rx_point_test_responder_if #(
  parameter int MSG_W     = 4,
  parameter int NUM_LANES = 16
);
  logic                 i_sb_msg_valid;
  logic [MSG_W-1:0]     i_sb_msg;
  logic                 i_sb_ready;
  logic                 o_sb_valid;
  logic [MSG_W-1:0]     o_sb_msg;
  logic [NUM_LANES-1:0] o_sb_data;

  modport master (
    output i_sb_msg_valid, i_sb_msg, i_sb_ready,
    input  o_sb_valid, o_sb_msg, o_sb_data
  );

  modport slave (
    input  i_sb_msg_valid, i_sb_msg, i_sb_ready,
    output o_sb_valid, o_sb_msg, o_sb_data
  );
endinterface

// File: rtl/rx_point_test_responder_timeout.sv
// Wait-state watchdog: down-counter reloaded by clr_i, decremented while en_i,
// expired_o asserted on the last allowed cycle of a wait.
module rx_pt_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: asynchronous active-low reset in the sensitivity list; all state
  // registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD_VAL;
    end else if (clr_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/rx_point_test_responder.sv
// RX-side responder for the TX-initiated point test: sequences the sideband
// start/clear/result/end exchange and drives the pattern comparators and vref.
// Optional build macro RX_PT_LANE_MASK_EN adds i_lane_mask (masked lanes pass).
module rx_point_test_responder
  import rx_pt_pkg::*;
#(
  parameter int NUM_LANES      = 16,
  parameter int MSG_W          = 4,
  parameter int VREF_W         = 4,
  parameter int VREF_TEST      = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [1:0]           i_mode,
  input  logic                 i_pattern_done,
  input  logic                 i_cmp_ack,
  input  logic [NUM_LANES-1:0] i_cmp_results,
`ifdef RX_PT_LANE_MASK_EN
  input  logic [NUM_LANES-1:0] i_lane_mask,
`endif
  rx_point_test_responder_if.slave sb,
  output logic [1:0]           o_cmp_cw,
  output logic                 o_cmp_valid_en,
  output logic [VREF_W-1:0]    o_vref,
  output logic                 o_done,
  output logic                 o_timeout_err
);

  typedef struct packed {
    logic                 sb_valid;
    logic [MSG_W-1:0]     sb_msg;
    logic [NUM_LANES-1:0] sb_data;
    cmp_cw_e              cmp_cw;
    logic                 cmp_valid_en;
    logic [VREF_W-1:0]    vref;
    logic                 done;
    logic                 timeout_err;
  } out_t;

  state_e               state_q;
  out_t                 out_q;
  logic                 armed_q;  // comparators configured, awaiting i_cmp_ack
  logic [NUM_LANES-1:0] cmp_data_d;
  logic                 rx_start, rx_clr, rx_res, rx_end;
  logic                 capture, tmr_clr, tmr_en, tmr_expired;

`ifdef RX_PT_LANE_MASK_EN
  assign cmp_data_d = i_cmp_results | i_lane_mask;
`else
  assign cmp_data_d = i_cmp_results;
`endif

  assign rx_start = sb.i_sb_msg_valid && (sb.i_sb_msg == MSG_W'(MSG_START_REQ));
  assign rx_clr   = sb.i_sb_msg_valid && (sb.i_sb_msg == MSG_W'(MSG_CLR_REQ));
  assign rx_res   = sb.i_sb_msg_valid && (sb.i_sb_msg == MSG_W'(MSG_RES_REQ));
  assign rx_end   = sb.i_sb_msg_valid && (sb.i_sb_msg == MSG_W'(MSG_END_REQ));

  // COMPARE hands straight over to WAIT_RES, so the capture also restarts the watchdog.
  assign capture = (state_q == ST_COMPARE) && armed_q && i_cmp_ack;
  assign tmr_en  = is_timed(state_q);
  assign tmr_clr = !tmr_en || capture;

  rx_pt_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      armed_q <= 1'b0;
    end else if (!i_en) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      armed_q <= 1'b0;
    end else if (tmr_expired) begin
      state_q                 <= ST_ERROR;
      out_q                   <= '0;
      out_q.timeout_err       <= 1'b1;
      armed_q                 <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_WAIT_START;

        ST_WAIT_START: if (rx_start) begin
          state_q        <= ST_SEND_START;
          out_q.sb_valid <= 1'b1;
          out_q.sb_msg   <= MSG_W'(MSG_START_RESP);
        end

        ST_SEND_START: if (sb.i_sb_ready) begin
          state_q        <= ST_WAIT_CLR;
          out_q.sb_valid <= 1'b0;
        end

        ST_WAIT_CLR: if (rx_clr) begin
          state_q        <= ST_SEND_CLR;
          out_q.sb_valid <= 1'b1;
          out_q.sb_msg   <= MSG_W'(MSG_CLR_RESP);
          out_q.cmp_cw   <= CW_CLR;
        end

        ST_SEND_CLR: if (sb.i_sb_ready) begin
          state_q        <= ST_COMPARE;
          out_q.sb_valid <= 1'b0;
          armed_q        <= 1'b0;
        end

        ST_COMPARE: begin
          // An ack coinciding with pattern_done belongs to no configured compare.
          if (!armed_q) begin
            if (i_pattern_done) begin
              armed_q            <= 1'b1;
              out_q.vref         <= VREF_W'(VREF_TEST);
              out_q.cmp_cw       <= mode_to_cw(i_mode);
              out_q.cmp_valid_en <= i_mode[MODE_VALID_BIT];
            end
          end else if (i_cmp_ack) begin
            state_q            <= ST_WAIT_RES;
            armed_q            <= 1'b0;
            out_q.sb_data      <= cmp_data_d;
            out_q.cmp_cw       <= CW_OFF;
            out_q.cmp_valid_en <= 1'b0;
          end
        end

        ST_WAIT_RES, ST_WAIT_END: begin
          if (rx_start) begin
            state_q            <= ST_SEND_START;
            out_q.sb_valid     <= 1'b1;
            out_q.sb_msg       <= MSG_W'(MSG_START_RESP);
            out_q.cmp_cw       <= CW_OFF;
            out_q.cmp_valid_en <= 1'b0;
            out_q.vref         <= '0;
          end else if (state_q == ST_WAIT_RES && rx_res) begin
            state_q        <= ST_SEND_RES;
            out_q.sb_valid <= 1'b1;
            out_q.sb_msg   <= MSG_W'(MSG_RES_RESP);
          end else if (state_q == ST_WAIT_END && rx_end) begin
            state_q        <= ST_SEND_END;
            out_q.sb_valid <= 1'b1;
            out_q.sb_msg   <= MSG_W'(MSG_END_RESP);
          end
        end

        ST_SEND_RES: if (sb.i_sb_ready) begin
          state_q        <= ST_WAIT_END;
          out_q.sb_valid <= 1'b0;
        end

        ST_SEND_END: if (sb.i_sb_ready) begin
          state_q        <= ST_DONE;
          out_q.sb_valid <= 1'b0;
          out_q.done     <= 1'b1;
          out_q.vref     <= '0;
        end

        ST_DONE, ST_ERROR: ;  // held until i_en drops

        default: begin
          state_q <= ST_IDLE;
          out_q   <= '0;
        end
      endcase
    end
  end

  assign sb.o_sb_valid   = out_q.sb_valid;
  assign sb.o_sb_msg     = out_q.sb_msg;
  assign sb.o_sb_data    = out_q.sb_data;
  assign o_cmp_cw        = out_q.cmp_cw;
  assign o_cmp_valid_en  = out_q.cmp_valid_en;
  assign o_vref          = out_q.vref;
  assign o_done          = out_q.done;
  assign o_timeout_err   = out_q.timeout_err;

endmodule

// File: tb/tb_rx_point_test_responder.sv
// Directed self-checking bench for rx_point_test_responder (16 lanes, 50-cycle
// timeout); define RX_PT_LANE_MASK_EN to also exercise the lane mask.
module tb_rx_point_test_responder;

  localparam int NUM_LANES = 16;
  localparam int MSG_W     = 4;
  localparam int VREF_W    = 4;
  localparam int TMO       = 50;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [1:0]           mode;
  logic                 pattern_done;
  logic                 cmp_ack;
  logic [NUM_LANES-1:0] cmp_results;
  logic [NUM_LANES-1:0] lane_mask;
  logic [1:0]           cmp_cw;
  logic                 cmp_valid_en;
  logic [VREF_W-1:0]    vref;
  logic                 done;
  logic                 timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  rx_point_test_responder_if #(.MSG_W(MSG_W), .NUM_LANES(NUM_LANES)) sb_if ();

  rx_point_test_responder #(
    .NUM_LANES      (NUM_LANES),
    .MSG_W          (MSG_W),
    .VREF_W         (VREF_W),
    .VREF_TEST      (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (en),
    .i_mode         (mode),
    .i_pattern_done (pattern_done),
    .i_cmp_ack      (cmp_ack),
    .i_cmp_results  (cmp_results),
`ifdef RX_PT_LANE_MASK_EN
    .i_lane_mask    (lane_mask),
`endif
    .sb             (sb_if.slave),
    .o_cmp_cw       (cmp_cw),
    .o_cmp_valid_en (cmp_valid_en),
    .o_vref         (vref),
    .o_done         (done),
    .o_timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input logic [MSG_W-1:0] code);
    sb_if.i_sb_msg_valid = 1'b1;
    sb_if.i_sb_msg       = code;
    tick();
    sb_if.i_sb_msg_valid = 1'b0;
    sb_if.i_sb_msg       = '0;
  endtask

  // Wait (bounded) for a response, check its code, accept it, check it drops.
  task automatic expect_resp(input string tag, input logic [MSG_W-1:0] code);
    int n;
    n = 0;
    while (!sb_if.o_sb_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(sb_if.o_sb_valid), 64'd1);
    check({tag, "_msg"},   64'(sb_if.o_sb_msg),   64'(code));
    sb_if.i_sb_ready = 1'b1;
    tick();
    sb_if.i_sb_ready = 1'b0;
    check({tag, "_drop"},  64'(sb_if.o_sb_valid), 64'd0);
  endtask

  task automatic pulse_pattern_done();
    pattern_done = 1'b1;
    tick();
    pattern_done = 1'b0;
  endtask

  task automatic pulse_ack(input logic [NUM_LANES-1:0] res);
    cmp_results = res;
    cmp_ack     = 1'b1;
    tick();
    cmp_ack     = 1'b0;
  endtask

  // From IDLE through START and CLR handshakes, leaving the DUT in COMPARE.
  task automatic start_flow(input logic [1:0] m);
    en   = 1'b1;
    mode = m;
    tick();
    send_msg(4'd1);
    expect_resp("start", 4'd2);
    send_msg(4'd3);
    check("clr_cw", 64'(cmp_cw), 64'd1);
    expect_resp("clr", 4'd4);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({sb_if.o_sb_valid, sb_if.o_sb_msg, sb_if.o_sb_data,
                cmp_cw, cmp_valid_en, vref, done, timeout_err});
  endfunction

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    mode = 2'b00;
    pattern_done = 1'b0;
    cmp_ack = 1'b0;
    cmp_results = '0;
    lane_mask = '0;
    sb_if.i_sb_msg_valid = 1'b0;
    sb_if.i_sb_msg = '0;
    sb_if.i_sb_ready = 1'b0;
    #12;
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full LFSR flow
    start_flow(2'b00);
    check("lfsr_cw_pre", 64'(cmp_cw), 64'd1);
    check("lfsr_vref_pre", 64'(vref), 64'd0);
    pulse_pattern_done();
    check("lfsr_cw", 64'(cmp_cw), 64'd2);
    check("lfsr_vref", 64'(vref), 64'd8);
    check("lfsr_ven", 64'(cmp_valid_en), 64'd0);
    tick();
    check("compare_no_valid", 64'(sb_if.o_sb_valid), 64'd0);
    pulse_ack(16'hFFF0);
    check("wres_cw", 64'(cmp_cw), 64'd0);
    check("wres_data", 64'(sb_if.o_sb_data), 64'hFFF0);
    send_msg(4'd5);
    check("res_data", 64'(sb_if.o_sb_data), 64'hFFF0);
    expect_resp("res", 4'd6);
    send_msg(4'd7);
    expect_resp("end", 4'd8);
    check("done", 64'(done), 64'd1);
    check("done_vref", 64'(vref), 64'd0);
    en = 1'b0;
    tick();
    check("done_clear", 64'(done), 64'd0);

    // Backpressure in SEND_START, then timeout in WAIT_CLR
    en = 1'b1;
    mode = 2'b00;
    tick();
    send_msg(4'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i),
            64'({sb_if.o_sb_valid, sb_if.o_sb_msg}), 64'({1'b1, 4'd2}));
      tick();
    end
    sb_if.i_sb_ready = 1'b1;
    tick();
    sb_if.i_sb_ready = 1'b0;
    check("bp_drop", 64'(sb_if.o_sb_valid), 64'd0);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("tmo_not_yet", 64'(timeout_err), 64'd0);
    check("tmo_one_xfer", 64'(sb_if.o_sb_valid), 64'd0);
    tick();
    check("tmo_err", 64'(timeout_err), 64'd1);
    check("tmo_outs", all_outs(), 64'd1);
    en = 1'b0;
    tick();
    check("tmo_clear", 64'(timeout_err), 64'd0);

    // Valid-train mode, then START_REQ restart from WAIT_END
    start_flow(2'b10);
    pulse_pattern_done();
    check("vt_ven", 64'(cmp_valid_en), 64'd1);
    check("vt_cw", 64'(cmp_cw), 64'd0);
    check("vt_vref", 64'(vref), 64'd8);
    pulse_ack(16'h1234);
    check("vt_ven_off", 64'(cmp_valid_en), 64'd0);
    check("vt_data", 64'(sb_if.o_sb_data), 64'h1234);
    send_msg(4'd9);
    check("unexpected_ignored", 64'(sb_if.o_sb_valid), 64'd0);
    send_msg(4'd5);
    expect_resp("vt_res", 4'd6);
    check("wend_vref", 64'(vref), 64'd8);
    send_msg(4'd1);
    check("restart_vref", 64'(vref), 64'd0);
    expect_resp("restart", 4'd2);
    en = 1'b0;
    tick();

    // Abort in COMPARE, then fresh flow with coincident pattern_done/ack
    start_flow(2'b01);
    pulse_pattern_done();
    check("pl_cw", 64'(cmp_cw), 64'd3);
    en = 1'b0;
    tick();
    check("abort_outs", all_outs(), 64'd0);
    start_flow(2'b00);
    cmp_results  = 16'h00FF;
    pattern_done = 1'b1;
    cmp_ack      = 1'b1;
    tick();
    pattern_done = 1'b0;
    cmp_ack      = 1'b0;
    check("coinc_cw", 64'(cmp_cw), 64'd2);
    check("coinc_no_cap", 64'(sb_if.o_sb_data), 64'd0);
    tick();
    pulse_ack(16'h00FF);
    check("late_ack_data", 64'(sb_if.o_sb_data), 64'h00FF);
    check("late_ack_cw", 64'(cmp_cw), 64'd0);
    send_msg(4'd5);
    expect_resp("f_res", 4'd6);
    send_msg(4'd7);
    expect_resp("f_end", 4'd8);
    check("f_done", 64'(done), 64'd1);
    en = 1'b0;
    tick();

`ifdef RX_PT_LANE_MASK_EN
    lane_mask = 16'h000F;
    start_flow(2'b00);
    pulse_pattern_done();
    pulse_ack(16'h0F00);
    check("mask_data", 64'(sb_if.o_sb_data), 64'h0F0F);
    en = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
